// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: issues reads to a FIFO with one-cycle read latency and
// presents the returned words as a valid/ready stream with packet framing.
// A 2-entry skid buffer plus an in-flight count keep back-to-back reads
// going at one beat per cycle without ever overrunning the buffer.
module fifo_rd_streamer #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  underflow_err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OCC_W = 2;
  localparam int unsigned LVL_W = 3;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);
  localparam logic [LVL_W-1:0] BUF_DEPTH = LVL_W'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [OCC_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [FIFO_WIDTH-1:0] data0_q, data0_d;
  logic [FIFO_WIDTH-1:0] data1_q, data1_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  busy_q, busy_d;
  logic                  underflow_err_q, underflow_err_d;

  logic                  pop_c;
  logic                  capture_c;
  logic [OCC_W-1:0]      occ_after_pop_c;
  logic [LVL_W-1:0]      level_c;

  assign pop_c     = m_valid_q & m_ready;
  assign capture_c = (inflight_q != '0);
  assign level_c   = LVL_W'(occ_q) + LVL_W'(inflight_q) - LVL_W'(pop_c);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; drain completes once nothing is buffered or pending.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (!en) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (en) begin
          state_d = S_RUN;
        end else if ((inflight_d == '0) && (occ_d == '0)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read request: only when buffer space covers everything already requested.
  always_comb begin
    rd_en = 1'b0;
    if ((state_q == S_RUN) && !fifo_empty && !rst && (level_c < BUF_DEPTH)) begin
      rd_en = 1'b1;
    end
  end

  // Buffer, counters and registered stream outputs.
  always_comb begin
    occ_after_pop_c = occ_q - OCC_W'(pop_c);
    occ_d           = occ_after_pop_c + OCC_W'(capture_c);
    inflight_d      = inflight_q + OCC_W'(rd_en) - OCC_W'(capture_c);

    data0_d = data0_q;
    data1_d = data1_q;
    if (pop_c) begin
      data0_d = data1_q;
    end
    if (capture_c) begin
      if (occ_after_pop_c == '0) begin
        data0_d = fifo_dout;
      end else begin
        data1_d = fifo_dout;
      end
    end

    beat_cnt_d = beat_cnt_q;
    if (pop_c) begin
      beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
    end

    m_valid_d       = (occ_d != '0);
    m_last_d        = (occ_d != '0) && (beat_cnt_d == LAST_BEAT);
    busy_d          = (state_d != S_IDLE);
    underflow_err_d = underflow_err_q | fifo_underflow;
  end

  // Datapath registers; reset discards buffered and in-flight beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q           <= '0;
      inflight_q      <= '0;
      beat_cnt_q      <= '0;
      data0_q         <= '0;
      data1_q         <= '0;
      m_valid_q       <= 1'b0;
      m_last_q        <= 1'b0;
      busy_q          <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      occ_q           <= occ_d;
      inflight_q      <= inflight_d;
      beat_cnt_q      <= beat_cnt_d;
      data0_q         <= data0_d;
      data1_q         <= data1_d;
      m_valid_q       <= m_valid_d;
      m_last_q        <= m_last_d;
      busy_q          <= busy_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_data        = data0_q;
  assign m_last        = m_last_q;
  assign busy          = busy_q;
  assign underflow_err = underflow_err_q;

endmodule
